aes_round_ctrl: RTL
===================

Name: aes_round_ctrl

Overview:
- Sequencer for the AES-128 encryption datapath. Drives the one-cycle en/done handshakes of the AddRoundKey, SubBytes, ShiftRows and MixColumns stage modules in Rijndael order.
- Steers the AddRoundKey input mux and presents the round index to the key schedule.
- Sits between the top-level cipher wrapper (start/done) and the stage modules.

Parameters:
- NR, 10, number of cipher rounds after the initial AddRoundKey (10 for AES-128).
- TIMEOUT_CYCLES, 16, max cycles to wait for a stage done_i (used only with the optional feature).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  begin encryption; sampled only in IDLE.
- busy_o  output  1  high while a block is in flight.
- done_o  output  1  one-cycle pulse when the ciphertext is valid at the AddRoundKey output.
- err_o  output  1  stage timeout flag (optional feature).
- round_o  output  4  current round index 0..NR, for the key schedule (key_i = round key[round_o]).
- ark_sel_o  output  2  AddRoundKey input select: 0 = plaintext, 1 = MixColumns out, 2 = ShiftRows out.
- ark_en_o, sb_en_o, sr_en_o, mc_en_o  output  1 each  stage enables.
- ark_done_i, sb_done_i, sr_done_i, mc_done_i  input  1 each  stage done.

Behaviour:
- Reset (async, rst_n low):
  - State is IDLE.
  - All enables, busy_o, done_o and err_o are 0.
  - round_o = 0, ark_sel_o = 0.
- States: IDLE, W_ARK, W_SB, W_SR, W_MC.
- All outputs are registered.
- Issuing a stage: on the edge that enters W_x, x_en_o <= 1. On the next edge x_en_o <= 0. Every enable is exactly one cycle wide.
- In W_x, the controller waits for x_done_i == 1. done_i inputs are ignored in any state other than the matching W_x.
- IDLE + start_i:
  - round_o <= 0, ark_sel_o <= 0, busy_o <= 1.
  - Enter W_ARK (issue ARK).
- W_ARK + ark_done_i:
  - If round_o == NR: go to IDLE, done_o <= 1 for one cycle, busy_o <= 0 on the same edge.
  - Else: round_o <= round_o + 1, issue SB.
- W_SB + sb_done_i: issue SR.
- W_SR + sr_done_i:
  - If round_o == NR: ark_sel_o <= 2, issue ARK. The final round skips MixColumns.
  - Else: issue MC.
- W_MC + mc_done_i: ark_sel_o <= 1, issue ARK.
- round_o increments only on the W_ARK -> W_SB transition. It never exceeds NR and never wraps.
- ark_sel_o and round_o change on the same edge as ark_en_o rises, so they are stable while the stage samples.
- Latency with single-cycle stages (done_i one cycle after en):
  - 2 cycles per stage.
  - 1 + 4*(NR-1) + 3 = 40 stages for NR = 10.
  - start_i sampled at edge 0 -> done_o high in the cycle after edge 80.
- start_i while busy_o = 1 is ignored; there is no queueing.
- start_i on the same cycle done_o is high: the controller is in IDLE, so start_i is accepted.
- Reset mid-operation returns to IDLE immediately with all outputs at reset values. No done_o is produced for the aborted block.
- Stages that take longer (done_i delayed) stretch the wait states. The controller keeps no other timing assumption.

Optional Feature:
- Macro: AES_ROUND_CTRL_TIMEOUT_EN.
- Defined:
  - A wait counter clears on every stage issue and increments each cycle in a W_x state.
  - If it reaches TIMEOUT_CYCLES without the matching done_i: go to IDLE, busy_o <= 0, err_o <= 1, no done_o.
  - err_o is sticky until the next accepted start_i, which clears it.
- Not defined:
  - Wait states last indefinitely.
  - err_o is tied to 0.
  - No counter logic is present.

Test Plan:
- Reset then single start_i pulse with single-cycle stage models (done_i = en delayed 1 cycle):
  - exactly 40 enable pulses in the order ARK, (SB, SR, MC, ARK) x 9, SB, SR, ARK.
  - done_o pulses once, 80 cycles after start_i.
  - mc_en_o never fires with round_o = 10.
- Same run, check ark_sel_o and round_o at each ark_en_o:
  - sel = 0 with round 0.
  - sel = 1 with rounds 1..9.
  - sel = 2 with round 10.
- start_i held high for 100 cycles:
  - second block begins the cycle after done_o; no restart mid-block.
  - busy_o has exactly one 1-cycle gap.
- sb_done_i delayed by 5 cycles in round 3:
  - total latency 85 cycles.
  - stray done_i pulses injected in W_SR are ignored.
- rst_n asserted during round 5 W_MC:
  - all outputs 0 immediately.
  - a new start_i after release completes normally in 80 cycles.
- With AES_ROUND_CTRL_TIMEOUT_EN, mc_done_i stuck low:
  - err_o = 1 and busy_o = 0 after 16 wait cycles, no done_o.
  - next start_i clears err_o and completes.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl -- round sequencer for the AES-128 encryption datapath.
//
// Each stage module (AddRoundKey, SubBytes, ShiftRows, MixColumns) gets a
// one-cycle enable pulse and answers with a done pulse. The stages run in
// Rijndael order:
//   ARK, (SB, SR, MC, ARK) x (NR-1), SB, SR, ARK
// The controller also steers the AddRoundKey input mux and presents the
// round index to the key schedule. Every output comes straight from a flop.
//
// Ports:
//   clk_i, rst_n          clock (rising edge), asynchronous active-low reset
//   start_i               begin a block; sampled only while idle
//   busy_o                a block is in flight
//   done_o                1-cycle pulse, ciphertext valid at the ARK output
//   err_o                 sticky stage-timeout flag (0 unless timeout build)
//   round_o[3:0]          round index 0..NR for the key schedule
//   ark_sel_o[1:0]        ARK input: 0 plaintext, 1 MixColumns, 2 ShiftRows
//   *_en_o / *_done_i     stage enable / done handshakes
//
// Build option: define AES_ROUND_CTRL_TIMEOUT_EN to abort a block when a
// stage fails to answer within TIMEOUT_CYCLES wait cycles.
module aes_round_ctrl #(
  parameter int unsigned NR             = 10,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [3:0] round_o,
  output logic [1:0] ark_sel_o,
  output logic       ark_en_o,
  output logic       sb_en_o,
  output logic       sr_en_o,
  output logic       mc_en_o,
  input  logic       ark_done_i,
  input  logic       sb_done_i,
  input  logic       sr_done_i,
  input  logic       mc_done_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_W_ARK = 3'd1,
    S_W_SB  = 3'd2,
    S_W_SR  = 3'd3,
    S_W_MC  = 3'd4
  } state_e;

  localparam logic [3:0] LAST_RND = 4'(NR);
  localparam logic [1:0] SEL_PT   = 2'd0;
  localparam logic [1:0] SEL_MC   = 2'd1;
  localparam logic [1:0] SEL_SR   = 2'd2;

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ark_en_q, ark_en_d;
  logic       sb_en_q, sb_en_d;
  logic       sr_en_q, sr_en_d;
  logic       mc_en_q, mc_en_d;
  logic       stage_done;  // done_i of the stage currently being waited on
  logic       timeout;

  // Only the done_i matching the current wait state is ever looked at.
  always_comb begin
    stage_done = 1'b0;
    case (state_q)
      S_W_ARK: stage_done = ark_done_i;
      S_W_SB:  stage_done = sb_done_i;
      S_W_SR:  stage_done = sr_done_i;
      S_W_MC:  stage_done = mc_done_i;
      default: stage_done = 1'b0;
    endcase
  end

`ifdef AES_ROUND_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  // The counter restarts whenever a stage is issued (start from idle or a
  // stage completing) and counts the cycles spent waiting otherwise.
  always_comb begin
    timeout    = (state_q != S_IDLE) && !stage_done &&
                 (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    wait_cnt_d = wait_cnt_q + 1'b1;
    if (state_q == S_IDLE || stage_done || timeout) wait_cnt_d = '0;
  end

  // Sticky until the next accepted start.
  always_comb begin
    err_d = err_q;
    if (state_q == S_IDLE && start_i) err_d = 1'b0;
    if (timeout)                      err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i)    state_d = S_W_ARK;
      S_W_ARK: if (ark_done_i) state_d = (round_q == LAST_RND) ? S_IDLE : S_W_SB;
      S_W_SB:  if (sb_done_i)  state_d = S_W_SR;
      // The final round skips MixColumns.
      S_W_SR:  if (sr_done_i)  state_d = (round_q == LAST_RND) ? S_W_ARK : S_W_MC;
      S_W_MC:  if (mc_done_i)  state_d = S_W_ARK;
      default:                 state_d = S_IDLE;
    endcase
    if (timeout) state_d = S_IDLE;
  end

  // Registered outputs. No state is ever re-entered from itself, so a stage
  // enable is simply "entering W_x on this edge", giving one-cycle pulses.
  always_comb begin
    round_d  = round_q;
    sel_d    = sel_q;
    done_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
    ark_en_d = (state_d == S_W_ARK) && (state_q != S_W_ARK);
    sb_en_d  = (state_d == S_W_SB)  && (state_q != S_W_SB);
    sr_en_d  = (state_d == S_W_SR)  && (state_q != S_W_SR);
    mc_en_d  = (state_d == S_W_MC)  && (state_q != S_W_MC);
    case (state_q)
      S_IDLE: if (start_i) begin
        round_d = '0;
        sel_d   = SEL_PT;
      end
      S_W_ARK: if (ark_done_i) begin
        if (round_q == LAST_RND) done_d  = 1'b1;
        else                     round_d = round_q + 4'd1;
      end
      S_W_SR: if (sr_done_i && round_q == LAST_RND) sel_d = SEL_SR;
      S_W_MC: if (mc_done_i) sel_d = SEL_MC;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      round_q  <= '0;
      sel_q    <= SEL_PT;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ark_en_q <= 1'b0;
      sb_en_q  <= 1'b0;
      sr_en_q  <= 1'b0;
      mc_en_q  <= 1'b0;
    end else begin
      round_q  <= round_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ark_en_q <= ark_en_d;
      sb_en_q  <= sb_en_d;
      sr_en_q  <= sr_en_d;
      mc_en_q  <= mc_en_d;
    end
  end

  assign round_o   = round_q;
  assign ark_sel_o = sel_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign ark_en_o  = ark_en_q;
  assign sb_en_o   = sb_en_q;
  assign sr_en_o   = sr_en_q;
  assign mc_en_o   = mc_en_q;

endmodule
